transform_pipe: RTL
===================

Name: transform_pipe

Overview:
Parametrised successor of the fixed 8-bit shift/rotate/zoom/to-screen chain. It maps a world coordinate to a screen position and a linear framebuffer address in four registered stages: translate, rotate, zoom, screen-map. Upstream and downstream connect through valid/ready handshakes with full backpressure. Per-beat configuration travels with the data, and off-screen points are either flagged or dropped.

Parameters:
CW, 8, unsigned input coordinate/center width
AW, 8, angle width; full circle = 2^AW
TW, 10, trig value width, signed Q2.(TW-2); 1.0 = 2^(TW-2)
ZW, 8, unsigned zoom width
ZF, 4, zoom fraction bits; 1.0 = 2^ZF
XRES, 320, screen width in pixels
YRES, 240, screen height in pixels
SW, 16, output screen coordinate width
ADDR_W, 17, linear address width
CLIP_MODE, 0, 0 = pass off-screen beats with out_clip=1; 1 = drop them

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
ENB  in  1  global enable; low freezes all state
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready&ENB
Xcoord, Ycoord  in  CW  unsigned world coordinate
Xcenter, Ycenter  in  CW  unsigned rotation/zoom center
Angle  in  AW  rotation angle, counter-clockwise
Zoom  in  ZW  unsigned zoom, ZF fraction bits
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
xAddr, yAddr  out  SW  screen coordinates (low SW bits)
Addr  out  ADDR_W  yAddr*XRES + xAddr
out_clip  out  1  beat is off-screen (CLIP_MODE=0 only; 0 otherwise)
drop_count  out  16  saturating count of dropped beats (CLIP_MODE=1)

Behaviour:
- Reset (async, ARESET=1): all stage valids 0; out_valid, xAddr, yAddr, Addr, out_clip and drop_count all 0. Reset mid-stream discards in-flight beats.
- ENB=0: no register changes, in_ready=0, outputs hold.
- Stage k holds v_k. ready_k = !v_k | ready_{k+1}; ready_5 = out_ready. in_ready = ready_1 & ENB. Stage k loads when ready_k & ENB. Bubbles collapse.
- Latency is 4 cycles from an accepted beat to out_valid with no stall. Throughput is 1 beat/cycle. Order is preserved. No beat is lost or duplicated under any out_ready pattern.
- S1 translate:
  - dx = Xcoord - Xcenter, dy = Ycoord - Ycenter, signed CW+1.
  - Angle and Zoom are registered alongside.
- S2 rotate:
  - c = cos(Angle), s = sin(Angle) come from the LUT.
  - xr = (dx*c - dy*s) >>> (TW-2); yr = (dx*s + dy*c) >>> (TW-2). Shifts are arithmetic (floor). Result width is signed CW+3.
- S3 zoom:
  - xz = (xr*Zoom) >>> ZF, and likewise for yz.
  - Full-width signed, with no truncation before the shift.
- S4 screen:
  - xs = xz + XRES/2; ys = YRES/2 - yz (y axis points up).
  - clip = !(0 <= xs < XRES && 0 <= ys < YRES), evaluated on full width.
  - xAddr/yAddr = low SW bits. Addr = ys*XRES + xs, taken when not clipped; 0 when clipped.
- CLIP_MODE=1:
  - A clipped beat in S4 is discarded and never presented on the output, and does not block the pipeline.
  - drop_count increments by 1 per discarded beat and saturates at 16'hFFFF.
- out_valid/data hold stable while out_valid & !out_ready.

Decomposition:
- Shared package transform_pkg holds:
  - the quadrant encoding of Angle (top 2 bits);
  - the fixed-point ONE constants 2^(TW-2) and 2^ZF;
  - the SCREEN_CX/SCREEN_CY constants.
- Sub-module trig_lut (combinational quarter-wave ROM):
  - entry[k] = round(2^(TW-2)*sin(2*pi*k/2^AW)) for k = 0..2^(AW-2). Entries at k=0 and k=2^(AW-2) are exactly 0 and ONE.
  - Quadrant folding and sign handling are done inside.
  - Outputs sin and cos; cos(a) = sin(a + 2^(AW-2)).
  - One instance in S2.

Test Plan:
Defaults throughout; Xcenter=Ycenter=0; Zoom=16 unless stated.
- Identity: X=10, Y=5, Angle=0 -> after 4 cycles xAddr=170, yAddr=115, Addr=36970, out_clip=0.
- Rotation 90 degrees: X=10, Y=5, Angle=64 -> (-5,10), so xAddr=155, yAddr=110, Addr=35355. Angle=128 -> xAddr=150, yAddr=125.
- Zoom: X=10, Y=5, Angle=0, Zoom=32 -> xAddr=180, yAddr=110, Addr=35380. Zoom=8 -> xAddr=165, yAddr=118.
- Clip: X=100, Y=0, Zoom=48 -> xs=460.
  - CLIP_MODE=0: beat out with out_clip=1, Addr=0.
  - CLIP_MODE=1: no output beat and drop_count=1; the next valid beat still emerges 4 cycles after its acceptance.
- Backpressure: stream 8 beats (X=0..7), hold out_ready=0 for 10 cycles, then random out_ready -> in_ready drops after 4 accepts; all 8 outputs appear in order with correct values and none lost or repeated.
- Reset/ENB: assert ARESET with 3 beats in flight -> out_valid=0 immediately and drop_count=0. Drop ENB for 5 cycles mid-stream -> outputs frozen, then resume with no loss.

Source files
------------

// File: rtl/transform_pkg.sv
`default_nettype none
// ============================================================================
// Module      : transform_pkg
// Description : Shared types, default geometry and fixed-point helpers for
//               the world-to-screen transform pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package transform_pkg;

   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quadrant_e;

   localparam int DEF_TW   = 10;
   localparam int DEF_ZF   = 4;
   localparam int DEF_XRES = 320;
   localparam int DEF_YRES = 240;

   function automatic int f_fix_one(input int frac);
      return 1 << frac;
   endfunction

   function automatic int f_screen_c(input int res);
      return res / 2;
   endfunction

   // round(ONE*sin(2*pi*k/2^aw)) for the first quadrant, Taylor series in Q30
   function automatic int f_quarter_sin(input int k, input int aw, input int tw);
      longint x, x2, term, sum;
      x    = (64'sd6746518852 * longint'(k)) >>> aw;
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 12; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return int'((sum * longint'(f_fix_one(tw - 2)) + (64'sd1 <<< 29)) >>> 30);
   endfunction

endpackage
`default_nettype wire

// File: rtl/transform_pipe_trig_lut.sv
`default_nettype none
// ============================================================================
// Module      : trig_lut
// Description : Combinational quarter-wave sine ROM with quadrant folding,
//               producing signed sin/cos of an AW-bit angle.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_lut
   import transform_pkg::*;
#(
   parameter int AW = 8,
   parameter int TW = DEF_TW
) (
   input  logic        [AW-1:0] i_angle,
   output logic signed [TW-1:0] o_sin,
   output logic signed [TW-1:0] o_cos
);

   localparam int c_QN = 1 << (AW - 2);
   localparam logic [AW-2:0] c_IDX_QN = (AW-1)'(c_QN);

   logic        [TW-1:0] w_rom [0:c_QN];
   logic        [AW-1:0] w_ang [2];
   logic        [AW-2:0] w_idx [2];
   logic signed [TW-1:0] w_val [2];

   for (genvar k = 0; k <= c_QN; k++) begin : g_rom
      localparam int c_VAL = f_quarter_sin(k, AW, TW);
      assign w_rom[k] = TW'(c_VAL);
   end

   // cos(a) is sin shifted forward by a quarter turn
   assign w_ang[0] = i_angle;
   assign w_ang[1] = i_angle + AW'(c_QN);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_idx[i] = {1'b0, w_ang[i][AW-3:0]};
         w_val[i] = '0;
         case (quadrant_e'(w_ang[i][AW-1:AW-2]))
            QUAD_0:  w_val[i] = signed'(w_rom[w_idx[i]]);
            QUAD_1:  w_val[i] = signed'(w_rom[c_IDX_QN - w_idx[i]]);
            QUAD_2:  w_val[i] = -signed'(w_rom[w_idx[i]]);
            default: w_val[i] = -signed'(w_rom[c_IDX_QN - w_idx[i]]);
         endcase
      end
   end

   assign o_sin = w_val[0];
   assign o_cos = w_val[1];

endmodule
`default_nettype wire

// File: rtl/transform_pipe.sv
`default_nettype none
// ============================================================================
// Module      : transform_pipe
// Description : Four-stage translate/rotate/zoom/screen-map pipeline with
//               valid/ready backpressure and optional off-screen dropping.
// Revision    : 1.0 - initial release
// ============================================================================
module transform_pipe
   import transform_pkg::*;
#(
   parameter int CW        = 8,
   parameter int AW        = 8,
   parameter int TW        = DEF_TW,
   parameter int ZW        = 8,
   parameter int ZF        = DEF_ZF,
   parameter int XRES      = DEF_XRES,
   parameter int YRES      = DEF_YRES,
   parameter int SW        = 16,
   parameter int ADDR_W    = 17,
   parameter int CLIP_MODE = 0
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              ENB,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW-1:0]     Xcoord,
   input  logic [CW-1:0]     Ycoord,
   input  logic [CW-1:0]     Xcenter,
   input  logic [CW-1:0]     Ycenter,
   input  logic [AW-1:0]     Angle,
   input  logic [ZW-1:0]     Zoom,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SW-1:0]     xAddr,
   output logic [SW-1:0]     yAddr,
   output logic [ADDR_W-1:0] Addr,
   output logic              out_clip,
   output logic [15:0]       drop_count
);

   localparam int c_DW  = CW + 1;
   localparam int c_PW  = c_DW + TW + 1;
   localparam int c_RW  = CW + 3;
   localparam int c_ZPW = c_RW + ZW + 1;
   localparam int c_SXW = c_ZPW + 2;
   localparam int c_CX  = f_screen_c(XRES);
   localparam int c_CY  = f_screen_c(YRES);

   logic r_v1, r_v2, r_v3, r_v4;
   logic w_rdy1, w_rdy2, w_rdy3, w_rdy4;

   logic signed [c_DW-1:0]  r_dx, r_dy;
   logic        [AW-1:0]    r_ang1;
   logic        [ZW-1:0]    r_zoom1, r_zoom2;
   logic signed [c_RW-1:0]  r_xr, r_yr;
   logic signed [c_ZPW-1:0] r_xz, r_yz;
   logic        [SW-1:0]    r_xaddr, r_yaddr;
   logic        [ADDR_W-1:0] r_addr;
   logic                    r_clip;
   logic        [15:0]      r_drop;

   logic signed [TW-1:0]    w_sin, w_cos;
   logic signed [c_PW-1:0]  w_sum_x, w_sum_y;
   logic signed [c_ZPW-1:0] w_zx, w_zy;
   logic signed [c_SXW-1:0] w_xs, w_ys;
   logic        [ADDR_W-1:0] w_addr;
   logic                    w_clip, w_drop;

   // A stage may load when empty or when its successor can take its beat
   assign w_rdy4   = !r_v4 || out_ready;
   assign w_rdy3   = !r_v3 || w_rdy4;
   assign w_rdy2   = !r_v2 || w_rdy3;
   assign w_rdy1   = !r_v1 || w_rdy2;
   assign in_ready = w_rdy1 && ENB;

   trig_lut #(
      .AW (AW),
      .TW (TW)
   ) u_trig (
      .i_angle (r_ang1),
      .o_sin   (w_sin),
      .o_cos   (w_cos)
   );

   assign w_sum_x = c_PW'(r_dx) * c_PW'(w_cos) - c_PW'(r_dy) * c_PW'(w_sin);
   assign w_sum_y = c_PW'(r_dx) * c_PW'(w_sin) + c_PW'(r_dy) * c_PW'(w_cos);

   assign w_zx = c_ZPW'(r_xr) * signed'(c_ZPW'(r_zoom2));
   assign w_zy = c_ZPW'(r_yr) * signed'(c_ZPW'(r_zoom2));

   assign w_xs   = c_SXW'(r_xz) + c_SXW'(c_CX);
   assign w_ys   = c_SXW'(c_CY) - c_SXW'(r_yz);
   assign w_clip = w_xs[c_SXW-1] || (w_xs >= c_SXW'(XRES)) ||
                   w_ys[c_SXW-1] || (w_ys >= c_SXW'(YRES));
   assign w_addr = ADDR_W'(w_ys) * ADDR_W'(XRES) + ADDR_W'(w_xs);
   assign w_drop = (CLIP_MODE == 1) && w_clip;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_v1    <= 1'b0;
         r_dx    <= '0;
         r_dy    <= '0;
         r_ang1  <= '0;
         r_zoom1 <= '0;
      end else if (w_rdy1 && ENB) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_dx    <= signed'({1'b0, Xcoord}) - signed'({1'b0, Xcenter});
            r_dy    <= signed'({1'b0, Ycoord}) - signed'({1'b0, Ycenter});
            r_ang1  <= Angle;
            r_zoom1 <= Zoom;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_v2    <= 1'b0;
         r_xr    <= '0;
         r_yr    <= '0;
         r_zoom2 <= '0;
      end else if (w_rdy2 && ENB) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_xr    <= c_RW'(w_sum_x >>> (TW - 2));
            r_yr    <= c_RW'(w_sum_y >>> (TW - 2));
            r_zoom2 <= r_zoom1;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_v3 <= 1'b0;
         r_xz <= '0;
         r_yz <= '0;
      end else if (w_rdy3 && ENB) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_xz <= w_zx >>> ZF;
            r_yz <= w_zy >>> ZF;
         end
      end
   end

   // Dropped beats never occupy the output stage, so they cannot stall it
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_v4    <= 1'b0;
         r_xaddr <= '0;
         r_yaddr <= '0;
         r_addr  <= '0;
         r_clip  <= 1'b0;
         r_drop  <= '0;
      end else if (w_rdy4 && ENB) begin
         r_v4 <= r_v3 && !w_drop;
         if (r_v3 && !w_drop) begin
            r_xaddr <= w_xs[SW-1:0];
            r_yaddr <= w_ys[SW-1:0];
            r_addr  <= w_clip ? '0 : w_addr;
            r_clip  <= w_clip;
         end
         if (r_v3 && w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
         end
      end
   end

   assign out_valid  = r_v4;
   assign xAddr      = r_xaddr;
   assign yAddr      = r_yaddr;
   assign Addr       = r_addr;
   assign out_clip   = r_clip;
   assign drop_count = r_drop;

endmodule
`default_nettype wire
